ppr_log_ctrl: RTL and testbench

//  Post-package-repair fail logger, successor to the single-slot-per-cycle PPR buffer. Collects fail records
//  (type, address) from N_CH memory-channel checkers via per-channel valid/ready, round-robin arbitrated,

---
 rtl/ppr_log_ctrl.sv | 155 +++++++++++++++
 tb/tb_ppr_log_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppr_log_ctrl.sv
// Post-package-repair fail logger: round-robin capture of per-channel fail records, then ordered drain on command.
// Define PPR_DEDUP_EN to drop records that duplicate an entry already held in the log.
module ppr_log_ctrl #(
    parameter int N_CH      = 32,
    parameter int ADDR_SIZE = 24,
    parameter int TYPE_W    = 2,
    parameter int CH_WIDTH  = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int DEPTH     = 256,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             ppr_valid_i,
    input  logic [N_CH*TYPE_W-1:0]      ppr_type_i,
    input  logic [N_CH*ADDR_SIZE-1:0]   ppr_addr_i,
    output logic [N_CH-1:0]             ppr_ready_o,
    input  logic                        ppr_cmd_i,
    output logic                        ppr_valid_o,
    input  logic                        ppr_ready_i,
    output logic [TYPE_W-1:0]           ppr_type_o,
    output logic [ADDR_SIZE-1:0]        ppr_addr_o,
    output logic [CH_WIDTH-1:0]         ppr_ch_o,
    output logic                        ppr_done_o,
    output logic                        ppr_busy_o,
    output logic [CNT_W-1:0]            ppr_count_o,
    output logic                        ppr_ovf_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {LOG = 1'b0, DRAIN = 1'b1} state_t;

    typedef struct packed {
        logic [TYPE_W-1:0]    typ;
        logic [ADDR_SIZE-1:0] addr;
        logic [CH_WIDTH-1:0]  ch;
    } rec_t;

    rec_t             buffer [DEPTH];
    state_t           state;
    logic [CNT_W-1:0] count, wr_ptr, rd_ptr, rd_nxt, count_next;
    logic [CH_WIDTH-1:0] rr_ptr, grant_ch;
    logic             grant_vld, dup, full, store, drop_full;
    logic [N_CH-1:0]  grant_oh;
    rec_t             new_rec, out_rec, first_rec;
    logic             out_valid, done, ovf;

    // Rotating-priority search starting at rr_ptr; no grants in DRAIN or while reset is asserted.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        grant_oh  = '0;
        if (state == LOG && !rst) begin
            for (int i = 0; i < N_CH; i++) begin
                idx = (int'(rr_ptr) + i) % N_CH;
                if (!grant_vld && ppr_valid_i[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = CH_WIDTH'(idx);
                end
            end
        end
        grant_oh[grant_ch] = grant_vld;
    end

    assign ppr_ready_o  = grant_oh;
    assign new_rec.typ  = ppr_type_i[grant_ch*TYPE_W +: TYPE_W];
    assign new_rec.addr = ppr_addr_i[grant_ch*ADDR_SIZE +: ADDR_SIZE];
    assign new_rec.ch   = grant_ch;

`ifdef PPR_DEDUP_EN
    always_comb begin
        dup = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) < count && buffer[j] == new_rec)
                dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign full       = (count == CNT_W'(DEPTH));
    assign store      = grant_vld && !dup && !full;
    assign drop_full  = grant_vld && !dup && full;
    assign count_next = store ? count + 1'b1 : count;
    assign rd_nxt     = rd_ptr + 1'b1;
    // Entry 0 may be written on the same edge that starts the drain, so forward it.
    assign first_rec  = (store && wr_ptr == '0) ? new_rec : buffer[0];

    // NOTE: the log storage has no reset; count bounds which entries are meaningful.
    always_ff @(posedge clk) begin
        if (store)
            buffer[wr_ptr[AW-1:0]] <= new_rec;
    end

    // NOTE: every register here uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOG;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rr_ptr    <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_rec   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == LOG) begin
                if (grant_vld)
                    rr_ptr <= (grant_ch == CH_WIDTH'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
                if (store)
                    wr_ptr <= wr_ptr + 1'b1;
                if (drop_full)
                    ovf <= 1'b1;
                count <= count_next;
                if (ppr_cmd_i) begin
                    if (count_next == '0) begin
                        done <= 1'b1;
                    end else begin
                        state     <= DRAIN;
                        rd_ptr    <= '0;
                        out_valid <= 1'b1;
                        out_rec   <= first_rec;
                    end
                end
            end else if (out_valid && ppr_ready_i) begin
                if (rd_ptr == count - 1'b1) begin
                    state     <= LOG;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                    count     <= '0;
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    ovf       <= 1'b0;
                end else begin
                    rd_ptr  <= rd_nxt;
                    out_rec <= buffer[rd_nxt[AW-1:0]];
                end
            end
        end
    end

    assign ppr_valid_o = out_valid;
    assign ppr_type_o  = out_rec.typ;
    assign ppr_addr_o  = out_rec.addr;
    assign ppr_ch_o    = out_rec.ch;
    assign ppr_done_o  = done;
    assign ppr_busy_o  = (state == DRAIN);
    assign ppr_count_o = count;
    assign ppr_ovf_o   = ovf;

endmodule

// File: tb/tb_ppr_log_ctrl.sv
// Scoreboard bench for ppr_log_ctrl (DEPTH=4): directed capture/drain scenarios, monitor checks drained records.
module tb_ppr_log_ctrl;
    localparam int N_CH      = 32;
    localparam int ADDR_SIZE = 24;
    localparam int TYPE_W    = 2;
    localparam int CH_WIDTH  = 5;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_CH-1:0]           ppr_valid_i;
    logic [N_CH*TYPE_W-1:0]    ppr_type_i;
    logic [N_CH*ADDR_SIZE-1:0] ppr_addr_i;
    logic [N_CH-1:0]           ppr_ready_o;
    logic                      ppr_cmd_i;
    logic                      ppr_valid_o;
    logic                      ppr_ready_i;
    logic [TYPE_W-1:0]         ppr_type_o;
    logic [ADDR_SIZE-1:0]      ppr_addr_o;
    logic [CH_WIDTH-1:0]       ppr_ch_o;
    logic                      ppr_done_o;
    logic                      ppr_busy_o;
    logic [CNT_W-1:0]          ppr_count_o;
    logic                      ppr_ovf_o;

    int tests  = 0;
    int failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_rec, prev_rec;
    logic        stall_prev = 1'b0;

    ppr_log_ctrl #(
        .N_CH(N_CH), .ADDR_SIZE(ADDR_SIZE), .TYPE_W(TYPE_W),
        .CH_WIDTH(CH_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ppr_valid_i(ppr_valid_i), .ppr_type_i(ppr_type_i), .ppr_addr_i(ppr_addr_i),
        .ppr_ready_o(ppr_ready_o), .ppr_cmd_i(ppr_cmd_i),
        .ppr_valid_o(ppr_valid_o), .ppr_ready_i(ppr_ready_i),
        .ppr_type_o(ppr_type_o), .ppr_addr_o(ppr_addr_o), .ppr_ch_o(ppr_ch_o),
        .ppr_done_o(ppr_done_o), .ppr_busy_o(ppr_busy_o),
        .ppr_count_o(ppr_count_o), .ppr_ovf_o(ppr_ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int ch, input int typ, input int addr);
        return {33'b0, CH_WIDTH'(ch), TYPE_W'(typ), ADDR_SIZE'(addr)};
    endfunction

    task automatic set_rec(input int ch, input int typ, input int addr);
        ppr_valid_i[ch] = 1'b1;
        ppr_type_i[ch*TYPE_W +: TYPE_W] = TYPE_W'(typ);
        ppr_addr_i[ch*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ppr_valid_i = '1;
        ppr_cmd_i = 1'b0;
        ppr_ready_i = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ppr_ready_o), 64'd0);
        check("rst_valid", 64'(ppr_valid_o), 64'd0);
        check("rst_count", 64'(ppr_count_o), 64'd0);
        @(posedge clk);
        #1;
        ppr_valid_i = '0;
        ppr_type_i = '0;
        ppr_addr_i = '0;
        rst = 1'b0;
    endtask

    // Issue a drain command and wait (bounded) for the completion pulse.
    task automatic drain_wait(input string name);
        ppr_cmd_i = 1'b1;
        tick();
        ppr_cmd_i = 1'b0;
        for (int k = 0; k < 40 && !ppr_done_o; k++) tick();
        check({name, "_done"}, 64'(ppr_done_o), 64'd1);
        check({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: compares every accepted drain record and checks stability across stalls.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else if (ppr_valid_o) begin
            cur_rec = {33'b0, ppr_ch_o, ppr_type_o, ppr_addr_o};
            if (stall_prev) check("hold_stable", cur_rec, prev_rec);
            if (ppr_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_drain actual=%0h required=none", cur_rec);
                end else begin
                    check("drain_rec", cur_rec, exp_q.pop_front());
                end
            end
            stall_prev = !ppr_ready_i;
            prev_rec   = cur_rec;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] one;
        int g2[3], t2[3], a2[3], pat[5];
        one = 32'd1;
        g2 = '{0, 5, 31};
        t2 = '{2, 3, 0};
        a2 = '{'h000111, 'h000555, 'hFFFF1F};
        pat = '{1, 0, 0, 1, 1};

        // 1: single record from ch3, drain it
        do_reset();
        check("t1_busy", 64'(ppr_busy_o), 64'd0);
        check("t1_ovf", 64'(ppr_ovf_o), 64'd0);
        check("t1_done", 64'(ppr_done_o), 64'd0);
        set_rec(3, 1, 'h00ABCD);
        @(negedge clk);
        check("t1_grant", 64'(ppr_ready_o), 64'h8);
        tick();
        ppr_valid_i = '0;
        check("t1_count", 64'(ppr_count_o), 64'd1);
        exp_q.push_back(pk(3, 1, 'h00ABCD));
        ppr_cmd_i = 1'b1;
        tick();
        ppr_cmd_i = 1'b0;
        check("t1_valid_t1", 64'(ppr_valid_o), 64'd1);
        check("t1_busy_drain", 64'(ppr_busy_o), 64'd1);
        tick();
        check("t1_done_pulse", 64'(ppr_done_o), 64'd1);
        check("t1_count_clr", 64'(ppr_count_o), 64'd0);
        check("t1_valid_off", 64'(ppr_valid_o), 64'd0);
        tick();
        check("t1_done_1cyc", 64'(ppr_done_o), 64'd0);

        // 2: three channels valid together, round-robin grants 0,5,31
        do_reset();
        for (int k = 0; k < 3; k++) set_rec(g2[k], t2[k], a2[k]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_grant", 64'(ppr_ready_o), 64'(one << g2[k]));
            exp_q.push_back(pk(g2[k], t2[k], a2[k]));
            tick();
            ppr_valid_i[g2[k]] = 1'b0;
        end
        check("t2_count", 64'(ppr_count_o), 64'd3);
        drain_wait("t2");

        // 3: overflow with DEPTH=4
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_rec(1, i % 4, 'h100 + i);
            @(negedge clk);
            check("t3_grant", 64'(ppr_ready_o), 64'h2);
            if (i < 4) exp_q.push_back(pk(1, i % 4, 'h100 + i));
            tick();
        end
        ppr_valid_i = '0;
        check("t3_count_full", 64'(ppr_count_o), 64'd4);
        check("t3_ovf_set", 64'(ppr_ovf_o), 64'd1);
        drain_wait("t3");
        check("t3_ovf_clr", 64'(ppr_ovf_o), 64'd0);
        check("t3_count_clr", 64'(ppr_count_o), 64'd0);

        // 4: back-pressure 1,0,0,1,1 over three entries
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_rec(7, i, 'h700 + i);
            exp_q.push_back(pk(7, i, 'h700 + i));
            tick();
        end
        ppr_valid_i = '0;
        check("t4_count", 64'(ppr_count_o), 64'd3);
        ppr_cmd_i = 1'b1;
        tick();
        ppr_cmd_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ppr_ready_i = pat[k][0];
            tick();
            if (k < 4) check("t4_no_early_done", 64'(ppr_done_o), 64'd0);
        end
        check("t4_done", 64'(ppr_done_o), 64'd1);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);
        ppr_ready_i = 1'b1;

        // 5: empty-log command, then command during DRAIN
        do_reset();
        ppr_cmd_i = 1'b1;
        tick();
        ppr_cmd_i = 1'b0;
        check("t5_empty_done", 64'(ppr_done_o), 64'd1);
        check("t5_empty_valid", 64'(ppr_valid_o), 64'd0);
        check("t5_empty_busy", 64'(ppr_busy_o), 64'd0);
        tick();
        check("t5_empty_done_off", 64'(ppr_done_o), 64'd0);
        check("t5_empty_valid2", 64'(ppr_valid_o), 64'd0);
        for (int i = 0; i < 2; i++) begin
            set_rec(9, 2, 'h900 + i);
            exp_q.push_back(pk(9, 2, 'h900 + i));
            tick();
        end
        ppr_valid_i = '0;
        ppr_ready_i = 1'b0;
        ppr_cmd_i = 1'b1;
        tick();
        set_rec(4, 1, 'h444);
        @(negedge clk);
        check("t5_no_grant_drain", 64'(ppr_ready_o), 64'd0);
        tick();
        ppr_cmd_i = 1'b0;
        ppr_valid_i = '0;
        check("t5_busy", 64'(ppr_busy_o), 64'd1);
        check("t5_count_hold", 64'(ppr_count_o), 64'd2);
        ppr_ready_i = 1'b1;
        for (int k = 0; k < 40 && !ppr_done_o; k++) tick();
        check("t5_done", 64'(ppr_done_o), 64'd1);
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // 6: duplicate record from ch2
        do_reset();
        set_rec(2, 0, 'h10);
        tick();
        tick();
        ppr_valid_i = '0;
`ifdef PPR_DEDUP_EN
        check("t6_count", 64'(ppr_count_o), 64'd1);
        exp_q.push_back(pk(2, 0, 'h10));
`else
        check("t6_count", 64'(ppr_count_o), 64'd2);
        exp_q.push_back(pk(2, 0, 'h10));
        exp_q.push_back(pk(2, 0, 'h10));
`endif
        drain_wait("t6");

        // 7: reset in the middle of a drain discards the log without a done pulse
        do_reset();
        set_rec(6, 3, 'h666);
        tick();
        ppr_valid_i = '0;
        ppr_ready_i = 1'b0;
        ppr_cmd_i = 1'b1;
        tick();
        ppr_cmd_i = 1'b0;
        check("t7_busy", 64'(ppr_busy_o), 64'd1);
        do_reset();
        check("t7_done", 64'(ppr_done_o), 64'd0);
        check("t7_valid", 64'(ppr_valid_o), 64'd0);
        check("t7_count", 64'(ppr_count_o), 64'd0);
        check("t7_busy_clr", 64'(ppr_busy_o), 64'd0);
        tick();
        check("t7_no_done", 64'(ppr_done_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
